// File: rtl/uart_arb_pkg.sv
// Shared state encoding, default parameters and counter-width helper
// for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_TX_BUSY = 2'd2,
    ST_TX_WAIT = 2'd3
  } arb_state_e;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_IDLE_TIMEOUT = 1024;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int DEF_BURST_W = cnt_width(DEF_MAX_BURST);
  localparam int DEF_TMO_W   = cnt_width(DEF_IDLE_TIMEOUT);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward,
// with wrap, from the index after ptr_i.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] w_cand;

  // Walk from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    w_cand = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      w_cand = IDX_W'((int'(ptr_i) + off) % N_REQ);
      if (req_i[w_cand]) begin
        gnt_o         = '0;
        gnt_o[w_cand] = 1'b1;
        idx_o         = w_cand;
        any_o         = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_phy transmitter between N_REQ byte-stream requesters;
// a grant covers a whole message (last flag, burst cap or idle timeout).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          grant_o,
  input  logic                      phy_rfd_i,
  output logic                      phy_nd_o,
  output logic [DATA_W-1:0]         phy_data_o,
  output logic                      busy_o
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BURST_W = cnt_width(MAX_BURST);
  localparam int TMO_W   = cnt_width(IDLE_TIMEOUT);

  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   PTR_RST   = IDX_W'(N_REQ - 1);

  arb_state_e          r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [N_REQ-1:0]    r_ready;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_ptr;
  logic [BURST_W-1:0]  r_burst;
  logic [TMO_W-1:0]    r_tmo;
  logic [DATA_W-1:0]   r_data;
  logic                r_last;
  logic                r_nd;
  logic                r_busy;

  logic [N_REQ-1:0]    w_pick_gnt;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic                w_own_valid;
  logic                w_own_last;
  logic [DATA_W-1:0]   w_own_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (r_ptr),
    .gnt_o (w_pick_gnt),
    .idx_o (w_pick_idx),
    .any_o (w_pick_any)
  );

  assign w_own_valid = req_valid_i[r_owner];
  assign w_own_last  = req_last_i[r_owner];
  assign w_own_data  = req_data_i[int'(r_owner)*DATA_W +: DATA_W];

  // Arbitration FSM with burst/timeout counters; every output is a register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ready <= '0;
      r_owner <= '0;
      r_ptr   <= PTR_RST;
      r_burst <= '0;
      r_tmo   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_nd    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= '0;
      r_nd    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant <= w_pick_gnt;
            r_owner <= w_pick_idx;
            r_burst <= '0;
            r_tmo   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_own_valid && phy_rfd_i) begin
            r_ready <= r_grant;
            r_data  <= w_own_data;
            r_last  <= w_own_last;
            r_tmo   <= '0;
            if (r_burst != BURST_CAP) begin
              r_burst <= r_burst + BURST_W'(1);
            end
            r_state <= ST_TX_BUSY;
          end else if (w_own_valid) begin
            // Owner is ready but the phy is not: hold without counting idle time.
            r_tmo <= '0;
          end else if (r_tmo >= TMO_LAST) begin
            r_grant <= '0;
            r_ptr   <= r_owner;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_TX_BUSY: begin
          // r_ready is high only on the first TX_BUSY cycle, giving one nd per byte.
          r_nd <= |r_ready;
          if (!phy_rfd_i) begin
            r_state <= ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          if (phy_rfd_i) begin
            if (r_last || (r_burst == BURST_CAP)) begin
              r_grant <= '0;
              r_ptr   <= r_owner;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_tmo   <= '0;
              r_state <= ST_GRANT;
            end
          end
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign grant_o     = r_grant;
  assign phy_nd_o    = r_nd;
  assign phy_data_o  = r_data;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: requester/phy models plus a message-level model
// that predicts grant order and bytes per grant from round-robin rules.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int TMO  = 16;

  typedef struct packed {
    logic [2:0] owner;
    logic [7:0] nbytes;
  } seg_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    ready;
  logic [N-1:0]    grant;
  logic            phy_rfd = 1'b1;
  logic            nd;
  logic [DW-1:0]   phy_data;
  logic            busy;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int ncyc = 0, ready_cnt = 0, nd_cnt = 0, seg_end_cnt = 0;
  int last_ready_ncyc = 0, last_nd_ncyc = 0, last_clear_ncyc = 0, last_rise_ncyc = 0;
  int frame_left = 0, phy_frame = 10, mptr = N - 1, seg_bytes = 0;
  bit phy_stall = 1'b0, in_seg = 1'b0;
  seg_t cur_seg;
  seg_t exp_seg_q[$];
  logic [7:0] acc_q[$];
  logic [8:0] rmem[N][64];
  int rhead[N], rtail[N];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N), .DATA_W(DW), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(ready), .grant_o(grant), .phy_rfd_i(phy_rfd),
    .phy_nd_o(nd), .phy_data_o(phy_data), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_msg(input int k, input int len, input bit with_last,
                          input logic [7:0] first, input bit rnd);
    logic [7:0] b;
    if (rhead[k] == rtail[k]) begin
      rhead[k] = 0;
      rtail[k] = 0;
    end
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : first + 8'(i);
      rmem[k][rtail[k]] = {with_last && (i == len - 1), b};
      rtail[k]++;
    end
  endtask

  // Message-level prediction: who owns the phy next and for how many bytes.
  task automatic plan();
    int h[N];
    int o, n, c;
    bit lst;
    seg_t s;
    for (int k = 0; k < N; k++) h[k] = rhead[k];
    for (int guard = 0; guard < 64; guard++) begin
      o = -1;
      for (int off = N; off >= 1; off--) begin
        c = (mptr + off) % N;
        if (h[c] < rtail[c]) o = c;
      end
      if (o < 0) break;
      n = 0;
      while (1) begin
        lst = rmem[o][h[o]][8];
        h[o]++;
        n++;
        if (lst || n == MAXB || h[o] == rtail[o]) break;
      end
      s.owner  = 3'(o);
      s.nbytes = 8'(n);
      exp_seg_q.push_back(s);
      mptr = o;
    end
  endtask

  function automatic int pending_bytes();
    int p = acc_q.size();
    for (int k = 0; k < N; k++) p += rtail[k] - rhead[k];
    return p;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    bit done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      if (exp_seg_q.size() == 0 && !in_seg && busy === 1'b0 && phy_rfd && frame_left == 0)
        done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_drained"}, pending_bytes(), 32'd0);
  endtask

  // Monitor, phy model and requester models, all evaluated away from the active edge.
  initial begin
    logic [31:0] exp_b;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        in_seg = 1'b0;
      end else if (!in_seg && grant != '0) begin
        in_seg    = 1'b1;
        seg_bytes = 0;
        if (exp_seg_q.size() == 0) begin
          check("grant_unexpected", 32'(grant), 32'd0);
        end else begin
          cur_seg = exp_seg_q.pop_front();
          check("grant_owner", 32'(grant), 32'd1 << cur_seg.owner);
          check("busy_granted", 32'(busy), 32'd1);
        end
      end
      if (ready != '0) begin
        ready_cnt++;
        last_ready_ncyc = ncyc;
        check("ready_owner", 32'(ready), in_seg ? (32'd1 << cur_seg.owner) : 32'd0);
        for (int k = 0; k < N; k++) begin
          if (ready[k] && rhead[k] < rtail[k]) begin
            acc_q.push_back(rmem[k][rhead[k]][7:0]);
            rhead[k]++;
          end
        end
      end
      if (nd) begin
        nd_cnt++;
        last_nd_ncyc = ncyc;
        seg_bytes++;
        exp_b = (acc_q.size() > 0) ? {24'd0, acc_q.pop_front()} : 32'h0000_0100;
        check("nd_data", 32'(phy_data), exp_b);
      end
      if (rst_n && in_seg && grant == '0) begin
        in_seg = 1'b0;
        seg_end_cnt++;
        last_clear_ncyc = ncyc;
        check("seg_bytes", 32'(seg_bytes), 32'(cur_seg.nbytes));
        check("busy_release", 32'(busy), 32'd0);
      end
      if (nd) frame_left = phy_frame;
      else if (frame_left > 0) frame_left--;
      if (phy_stall || frame_left > 0) begin
        phy_rfd = 1'b0;
      end else if (!phy_rfd) begin
        phy_rfd = 1'b1;
        last_rise_ncyc = ncyc;
      end
      for (int k = 0; k < N; k++) begin
        req_valid[k]         = rhead[k] < rtail[k];
        req_data[k*DW +: DW] = rmem[k][rhead[k]][7:0];
        req_last[k]          = rmem[k][rhead[k]][8];
      end
    end
  end

  initial begin
    int base, snap_r, snap_n, mask;
    for (int k = 0; k < N; k++) begin
      rhead[k] = 0;
      rtail[k] = 0;
      for (int i = 0; i < 64; i++) rmem[k][i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_nd", 32'(nd), 32'd0);
    check("rst_data", 32'(phy_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention from reset, then req0 alone, then contention again.
    phy_frame = 6;
    load_msg(0, 2, 1'b1, 8'h10, 1'b0);
    load_msg(2, 2, 1'b1, 8'h20, 1'b0);
    plan();
    wait_idle("contend_a", 400);
    load_msg(0, 1, 1'b1, 8'h30, 1'b0);
    plan();
    wait_idle("solo_req0", 200);
    load_msg(0, 2, 1'b1, 8'h50, 1'b0);
    load_msg(2, 2, 1'b1, 8'h60, 1'b0);
    plan();
    wait_idle("contend_b", 400);

    // Single message on req1.
    phy_frame = 10;
    load_msg(1, 3, 1'b1, 8'h41, 1'b0);
    plan();
    wait_idle("single_msg", 400);

    // Burst cap: req3 streams 6 bytes without last, req1 pending.
    load_msg(3, 6, 1'b0, 8'h70, 1'b0);
    load_msg(1, 2, 1'b1, 8'h80, 1'b0);
    plan();
    wait_idle("burst_cap", 1000);

    // Idle timeout on req0 with req1 pending.
    base = seg_end_cnt;
    load_msg(0, 1, 1'b0, 8'h90, 1'b0);
    load_msg(1, 3, 1'b1, 8'hA0, 1'b0);
    plan();
    for (int t = 0; t < 500 && seg_end_cnt == base; t++) @(negedge clk);
    check("timeout_release_seen", 32'(seg_end_cnt - base), 32'd1);
    check("timeout_latency", 32'(last_clear_ncyc - last_rise_ncyc), 32'(TMO + 1));
    wait_idle("timeout", 600);

    // rfd stall with owner valid high.
    phy_stall = 1'b1;
    repeat (3) @(negedge clk);
    load_msg(2, 2, 1'b1, 8'hB0, 1'b0);
    plan();
    repeat (6) @(negedge clk);
    snap_r = ready_cnt;
    snap_n = nd_cnt;
    repeat (50) @(negedge clk);
    check("stall_no_ready", 32'(ready_cnt), 32'(snap_r));
    check("stall_no_nd", 32'(nd_cnt), 32'(snap_n));
    check("stall_hold_grant", 32'(grant), 32'b0100);
    phy_stall = 1'b0;
    for (int t = 0; t < 20 && ready_cnt == snap_r; t++) @(negedge clk);
    for (int t = 0; t < 20 && nd_cnt == snap_n; t++) @(negedge clk);
    check("stall_accept_lat", 32'(last_ready_ncyc - last_rise_ncyc), 32'd1);
    check("stall_nd_lat", 32'(last_nd_ncyc - last_ready_ncyc), 32'd1);
    wait_idle("stall", 400);

    // Reset while the phy is still sending (TX_WAIT).
    phy_frame = 10;
    snap_n = nd_cnt;
    load_msg(0, 3, 1'b1, 8'hC0, 1'b0);
    plan();
    for (int t = 0; t < 200 && nd_cnt == snap_n; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) rhead[k] = rtail[k];
    exp_seg_q.delete();
    mptr = N - 1;
    snap_n = nd_cnt;
    @(negedge clk);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_nd", 32'(nd), 32'd0);
    check("mid_rst_data", 32'(phy_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_nd_after_rst", 32'(nd_cnt), 32'(snap_n));
    load_msg(0, 2, 1'b1, 8'hD0, 1'b0);
    load_msg(1, 2, 1'b1, 8'hE0, 1'b0);
    plan();
    wait_idle("post_rst", 600);

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      mask = $urandom_range(1, 15);
      phy_frame = $urandom_range(2, 12);
      for (int k = 0; k < N; k++) begin
        if (mask[k]) load_msg(k, $urandom_range(1, 6), ($urandom_range(0, 3) != 0), 8'h00, 1'b1);
      end
      plan();
      wait_idle("rand_round", 3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
